// File: rtl/axis_adxl_responder_if.sv
// AXI-Stream bundle used for both the request (slave) and response (master) sides
// of the ADXL345 register responder.
interface axis_adxl_responder_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic [7:0]  tdest;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    modport master (output tdata, tkeep, tdest, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tdest, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_adxl_responder.sv
// ADXL345 stand-in on AXI-Stream: answers register read/write request packets from a
// 64-byte register map and synthesises X/Y/Z samples while measurement is enabled.
module axis_adxl_responder #(
    parameter logic [6:0] DEVICE_ADDR     = 7'd52,
    parameter int         SAMPLE_INTERVAL = 1000
) (
    input  logic                         clk,
    input  logic                         resetn,
    axis_adxl_responder_if.slave         s_axis,
    axis_adxl_responder_if.master        m_axis,
    output logic                         MEASURE_EN
);
    localparam int            CW       = $clog2(SAMPLE_INTERVAL);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_INTERVAL - 1);

    localparam logic [5:0] A_DEVID      = 6'h00;
    localparam logic [5:0] A_BW_RATE    = 6'h2C;
    localparam logic [5:0] A_POWER_CTL  = 6'h2D;
    localparam logic [5:0] A_INT_SOURCE = 6'h30;
    localparam logic [5:0] A_DATAZ1     = 6'h37;

    typedef enum logic [1:0] {IDLE, WRITE, READ_RESP, DROP} state_t;

    function automatic logic [7:0] reset_val(input logic [5:0] a);
        case (a)
            A_DEVID:      return 8'hE5;
            A_BW_RATE:    return 8'h0A;
            A_INT_SOURCE: return 8'h02;
            default:      return 8'h00;
        endcase
    endfunction

    // Reserved ranges and read-only registers simply never accept a write.
    function automatic logic writable(input logic [5:0] a);
        return (a >= 6'h1D) && (a <= 6'h38) && (a != 6'h2B) && (a != A_INT_SOURCE)
            && !((a >= 6'h32) && (a <= A_DATAZ1));
    endfunction

    logic [7:0]    regs_q [64];
    logic [7:0]    regs_d [64];
    state_t        state_q, state_d;
    logic [5:0]    wr_ptr_q, wr_ptr_d;
    logic [5:0]    rd_ptr_q, rd_ptr_d;
    logic [6:0]    rd_left_q, rd_left_d;
    logic          drain_q, drain_d;
    logic          s_tready_q, s_tready_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic          m_tlast_q, m_tlast_d;
    logic [31:0]   m_tdata_q, m_tdata_d;
    logic [3:0]    m_tkeep_q, m_tkeep_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          measure_q, measure_d;

    logic          s_hs, m_hs, addr_match, load, wr_active;
    logic          measure_on, sample_wrap;
    logic [7:0]    req_raw;
    logic [6:0]    req_n;
    logic [5:0]    ld_ptr;
    logic [6:0]    ld_left;
    logic [2:0]    ld_cnt;
    logic          ld_last;
    logic [3:0]    ld_keep, ld_hit37, wr_lane_en;
    logic [31:0]   ld_data;
    logic [5:0]    wr_base;
    logic [5:0]    wr_addr [4];
    logic [2:0]    wr_total;
    logic [15:0]   x_next, y_next, z_next;

    assign s_hs       = s_axis.tvalid && s_tready_q;
    assign m_hs       = m_tvalid_q && m_axis.tready;
    assign addr_match = (s_axis.tdest[7:1] == DEVICE_ADDR);
    assign req_raw    = s_axis.tdata[15:8];
    assign req_n      = (req_raw == 8'd0) ? 7'd1 : (req_raw > 8'd64) ? 7'd64 : req_raw[6:0];
    assign wr_base    = (state_q == IDLE) ? s_axis.tdata[5:0] : wr_ptr_q;
    assign wr_total   = 3'($countones(wr_lane_en));

    assign measure_on  = regs_q[A_POWER_CTL][3];
    assign sample_wrap = measure_on && (cnt_q == CNT_LAST);
    assign x_next      = {regs_q[6'h33], regs_q[6'h32]} + 16'd1;
    assign y_next      = {regs_q[6'h35], regs_q[6'h34]} + 16'd2;
    assign z_next      = {regs_q[6'h37], regs_q[6'h36]} + 16'd3;

    // The first response beat is built straight from the request; later ones from the read pointer.
    always_comb begin
        if (state_q == IDLE) begin
            ld_ptr  = s_axis.tdata[5:0];
            ld_left = req_n;
        end else begin
            ld_ptr  = rd_ptr_q;
            ld_left = rd_left_q;
        end
        ld_cnt  = (ld_left >= 7'd4) ? 3'd4 : ld_left[2:0];
        ld_last = (ld_left <= 7'd4);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [5:0] rd_addr;
            assign rd_addr             = ld_ptr + 6'(gi);
            assign ld_keep[gi]         = (3'(gi) < ld_cnt);
            assign ld_data[8*gi +: 8]  = ld_keep[gi] ? regs_q[rd_addr] : 8'h00;
            assign ld_hit37[gi]        = ld_keep[gi] && (rd_addr == A_DATAZ1);
            // Byte 0 of the opening write beat carries the register pointer, not data.
            assign wr_lane_en[gi]      = s_axis.tkeep[gi] && ((gi != 0) || (state_q != IDLE));
            assign wr_addr[gi]         = wr_base + {3'b000, 3'($countones(wr_lane_en & 4'((1 << gi) - 1)))};
        end
    endgenerate

    always_comb begin
        regs_d     = regs_q;
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_left_d  = rd_left_q;
        drain_d    = drain_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        load       = 1'b0;
        wr_active  = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_hs) begin
                    if (!addr_match) begin
                        if (!s_axis.tlast) state_d = DROP;
                    end else if (s_axis.tdest[0]) begin
                        load    = 1'b1;
                        drain_d = !s_axis.tlast;
                        state_d = READ_RESP;
                    end else begin
                        wr_active = 1'b1;
                        if (!s_axis.tlast) state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (s_hs) begin
                    wr_active = 1'b1;
                    if (s_axis.tlast) state_d = IDLE;
                end
            end
            DROP: begin
                if (s_hs && s_axis.tlast) state_d = IDLE;
            end
            READ_RESP: begin
                if (m_hs) begin
                    if (m_tlast_q) begin
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                        m_tdata_d  = 32'h0;
                        m_tkeep_d  = 4'h0;
                        // Trailing beats of a multi-beat read request are discarded afterwards.
                        state_d    = drain_q ? DROP : IDLE;
                        drain_d    = 1'b0;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = ld_data;
            m_tkeep_d  = ld_keep;
            m_tlast_d  = ld_last;
            rd_ptr_d   = ld_ptr + {3'b000, ld_cnt};
            rd_left_d  = ld_left - {4'b0000, ld_cnt};
        end

        if (wr_active) begin
            wr_ptr_d = wr_base + {3'b000, wr_total};
            for (int l = 0; l < 4; l++) begin
                if (wr_lane_en[l] && writable(wr_addr[l])) regs_d[wr_addr[l]] = s_axis.tdata[8*l +: 8];
            end
        end

        cnt_d = (!measure_on || sample_wrap) ? '0 : cnt_q + CW'(1);
        if (sample_wrap) begin
            regs_d[6'h32] = x_next[7:0];
            regs_d[6'h33] = x_next[15:8];
            regs_d[6'h34] = y_next[7:0];
            regs_d[6'h35] = y_next[15:8];
            regs_d[6'h36] = z_next[7:0];
            regs_d[6'h37] = z_next[15:8];
        end
        // A new sample outranks the read-clear of DATA_READY in the same cycle.
        if (load && (|ld_hit37)) regs_d[A_INT_SOURCE][7] = 1'b0;
        if (sample_wrap)         regs_d[A_INT_SOURCE][7] = 1'b1;

        s_tready_d = (state_d != READ_RESP);
        measure_d  = measure_on;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 6'd0;
            rd_ptr_q   <= 6'd0;
            rd_left_q  <= 7'd0;
            drain_q    <= 1'b0;
            s_tready_q <= 1'b1;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tdata_q  <= 32'h0;
            m_tkeep_q  <= 4'h0;
            cnt_q      <= '0;
            measure_q  <= 1'b0;
            for (int i = 0; i < 64; i++) regs_q[i] <= reset_val(6'(i));
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_left_q  <= rd_left_d;
            drain_q    <= drain_d;
            s_tready_q <= s_tready_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tdata_q  <= m_tdata_d;
            m_tkeep_q  <= m_tkeep_d;
            cnt_q      <= cnt_d;
            measure_q  <= measure_d;
            regs_q     <= regs_d;
        end
    end

    assign s_axis.tready = s_tready_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = m_tlast_q;
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tkeep  = m_tkeep_q;
    assign m_axis.tdest  = {DEVICE_ADDR, 1'b1};
    assign MEASURE_EN    = measure_q;
endmodule

// File: tb/tb_axis_adxl_responder.sv
// Directed plus randomized bench for axis_adxl_responder; expected read data comes from a
// byte-array model of the ADXL345 register map updated by the register rules.
module tb_axis_adxl_responder;
    localparam int SI = 100;

    logic clk = 1'b0;
    logic resetn;
    logic measure_en;

    axis_adxl_responder_if s_if ();
    axis_adxl_responder_if m_if ();

    axis_adxl_responder #(.DEVICE_ADDR(7'd52), .SAMPLE_INTERVAL(SI)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_axis     (s_if.slave),
        .m_axis     (m_if.master),
        .MEASURE_EN (measure_en)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] mdl [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic bit wr_ok(input logic [5:0] a);
        return (a >= 6'h1D) && (a <= 6'h38) && (a != 6'h2B) && (a != 6'h30) && !(a inside {[6'h32:6'h37]});
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
        mdl[6'h00] = 8'hE5;
        mdl[6'h2C] = 8'h0A;
        mdl[6'h30] = 8'h02;
    endtask

    task automatic model_wr(input logic [5:0] a, input logic [7:0] b);
        if (wr_ok(a)) mdl[a] = b;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic [7:0] dst, input logic l);
        bit hs;
        int c;
        hs = 0;
        c  = 0;
        s_if.tdata = d; s_if.tkeep = k; s_if.tdest = dst; s_if.tlast = l; s_if.tvalid = 1'b1;
        while (!hs && c < 200) begin
            @(negedge clk);
            hs = s_if.tready;
            @(posedge clk); #1;
            c++;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        chk("s_handshake", 32'(hs), 32'd1);
    endtask

    task automatic collect(input logic [5:0] start, input int nbytes, input bit rnd);
        int nbeats, bi, cyc, idx;
        bit stalled, expect_v, hit;
        logic [31:0] hd, ed, mask;
        logic [3:0] hk, ek;
        logic hl;
        logic [5:0] a;
        nbeats = (nbytes + 3) / 4;
        bi = 0; cyc = 0; stalled = 0; expect_v = 1;
        hd = '0; hk = '0; hl = 0;
        while (bi < nbeats && cyc < 3000) begin
            m_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            chk("s_tready_low", 32'(s_if.tready), 32'd0);
            if (expect_v) chk("beat_valid_no_bubble", 32'(m_if.tvalid), 32'd1);
            expect_v = 0;
            if (m_if.tvalid) begin
                if (stalled) begin
                    chk("stall_data", m_if.tdata, hd);
                    chk("stall_keep", 32'(m_if.tkeep), 32'(hk));
                    chk("stall_last", 32'(m_if.tlast), 32'(hl));
                end
                if (m_if.tready) begin
                    ed = '0; ek = '0; hit = 0; mask = '0;
                    for (int l = 0; l < 4; l++) begin
                        idx = bi * 4 + l;
                        if (idx < nbytes) begin
                            a = start + 6'(idx);
                            ed[8*l +: 8]   = mdl[a];
                            mask[8*l +: 8] = 8'hFF;
                            ek[l] = 1'b1;
                            if (a == 6'h37) hit = 1;
                        end
                    end
                    chk("beat_data", m_if.tdata & mask, ed);
                    chk("beat_keep", 32'(m_if.tkeep), 32'(ek));
                    chk("beat_last", 32'(m_if.tlast), 32'(bi == nbeats - 1));
                    chk("beat_tdest", 32'(m_if.tdest), 32'h69);
                    if (hit) mdl[6'h30][7] = 1'b0;
                    bi++;
                    stalled  = 0;
                    expect_v = (bi < nbeats);
                end else begin
                    stalled = 1;
                    hd = m_if.tdata; hk = m_if.tkeep; hl = m_if.tlast;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("resp_beats_complete", 32'(bi), 32'(nbeats));
        m_if.tready = 1'b1;
        @(negedge clk);
        chk("tvalid_after_last", 32'(m_if.tvalid), 32'd0);
        chk("s_tready_after_resp", 32'(s_if.tready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic read_req(input logic [7:0] start, input logic [7:0] n, input bit rnd);
        int nb;
        nb = (n == 0) ? 1 : (n > 64) ? 64 : int'(n);
        send_beat({16'h0, n, start}, 4'h3, {7'd52, 1'b1}, 1'b1);
        collect(start[5:0], nb, rnd);
        $display("read  start=%02h n=%0d bytes=%0d random_ready=%0d", start, n, nb, rnd);
    endtask

    task automatic write1(input logic [5:0] ptr, input logic [7:0] b);
        model_wr(ptr, b);
        send_beat({16'h0, b, 2'b00, ptr}, 4'h3, {7'd52, 1'b0}, 1'b1);
        $display("write ptr=%02h data=%02h", ptr, b);
    endtask

    task automatic wr_random(input int nbeats);
        logic [5:0] p, p0;
        logic [31:0] d;
        logic [3:0] k;
        logic [7:0] b;
        int first;
        p  = 6'($urandom_range(0, 63));
        p0 = p;
        for (int bt = 0; bt < nbeats; bt++) begin
            d = $urandom;
            k = 4'($urandom_range(0, 15));
            first = (bt == 0) ? 1 : 0;
            if (bt == 0) begin
                k[0] = 1'b1;
                d[7:0] = {2'($urandom_range(0, 3)), p};
            end
            for (int l = first; l < 4; l++) begin
                if (k[l]) begin
                    b = d[8*l +: 8];
                    if (p == 6'h2D) begin
                        b[3] = 1'b0;
                        d[8*l + 3] = 1'b0;
                    end
                    model_wr(p, b);
                    p = p + 6'd1;
                end
            end
            send_beat(d, k, {7'd52, 1'b0}, 1'(bt == nbeats - 1));
        end
        $display("write random ptr=%02h beats=%0d", p0, nbeats);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        resetn = 1'b0;
        s_if.tdata = '0; s_if.tkeep = '0; s_if.tdest = '0; s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
        m_if.tready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 32'(s_if.tready), 32'd1);
        chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_if.tlast), 32'd0);
        chk("rst_m_tdata", m_if.tdata, 32'd0);
        chk("rst_m_tkeep", 32'(m_if.tkeep), 32'd0);
        chk("rst_measure_en", 32'(measure_en), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        $display("reset released");

        read_req(8'h00, 8'd1, 0);
        read_req(8'h2A, 8'd7, 0);

        write1(6'h2D, 8'h08);
        repeat (2 * SI + 10) @(posedge clk);
        #1;
        chk("measure_en_on", 32'(measure_en), 32'd1);
        mdl[6'h32] = 8'h02; mdl[6'h33] = 8'h00;
        mdl[6'h34] = 8'h04; mdl[6'h35] = 8'h00;
        mdl[6'h36] = 8'h06; mdl[6'h37] = 8'h00;
        mdl[6'h30][7] = 1'b1;
        read_req(8'h30, 8'd1, 0);
        read_req(8'h32, 8'd6, 0);
        read_req(8'h30, 8'd1, 0);
        write1(6'h2D, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("measure_en_off", 32'(measure_en), 32'd0);

        write1(6'h00, 8'h11);
        write1(6'h1E, 8'h55);
        read_req(8'h00, 8'd1, 0);
        read_req(8'h1E, 8'd1, 0);
        read_req(8'h3E, 8'd3, 0);
        read_req(8'h05, 8'd0, 0);

        send_beat(32'h0000_0400, 4'hF, {7'd53, 1'b1}, 1'b0);
        send_beat(32'h1234_5678, 4'hF, {7'd53, 1'b1}, 1'b0);
        send_beat(32'h9ABC_DEF0, 4'hF, {7'd53, 1'b1}, 1'b1);
        vcount = 0;
        repeat (10) begin
            @(negedge clk);
            vcount += int'(m_if.tvalid);
        end
        chk("drop_no_response", 32'(vcount), 32'd0);
        @(posedge clk); #1;
        $display("drop request to addr 53, 3 beats");
        read_req(8'h00, 8'd1, 0);

        read_req(8'h00, 8'd64, 1);
        read_req(8'h10, 8'd200, 1);

        for (int it = 0; it < 15; it++) begin
            wr_random($urandom_range(1, 3));
            read_req(8'($urandom), 8'($urandom_range(0, 80)), 1);
        end

        m_if.tready = 1'b0;
        send_beat({16'h0, 8'd64, 8'h00}, 4'h3, {7'd52, 1'b1}, 1'b1);
        @(negedge clk);
        chk("pre_reset_tvalid", 32'(m_if.tvalid), 32'd1);
        resetn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("midrst_tdata", m_if.tdata, 32'd0);
        chk("midrst_tkeep", 32'(m_if.tkeep), 32'd0);
        chk("midrst_s_tready", 32'(s_if.tready), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
        m_if.tready = 1'b1;
        model_reset();
        $display("reset during response");
        read_req(8'h2C, 8'd2, 0);
        read_req(8'h1E, 8'd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
